// File: rtl/reg_dump_pkg.sv
// Shared constants and FSM state encoding for the register-dump UART transmitter.
package reg_dump_pkg;

  localparam int WORD_W    = 32;
  localparam int BYTE_W    = 8;
  localparam int REG_COUNT = 32;

  // State codes are plain localparams so older tools and netlists see fixed values.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/reg_dump_uart_tx_byte.sv
// uart_byte_tx: one byte in, one serial frame out (8N1, or 8E1 when
// REG_DUMP_TX_PARITY_EN is defined). Owns the baud counter and bit index.
module uart_byte_tx
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              tx,
  output logic              done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic [2:0]        bit_idx_reg;
  logic [BYTE_W-1:0] byte_reg;
  logic              tx_reg;
  logic              tick;

  assign tick = (cnt_reg == CW'(CLKS_PER_BIT - 1));
  // Last cycle of the stop bit; a start on this cycle chains the next byte with no gap.
  assign done = (state_reg == ST_STOP) && tick;
  assign tx   = tx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      byte_reg    <= '0;
      tx_reg      <= 1'b1;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + CW'(1);
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (start) begin
            byte_reg  <= byte_in;
            state_reg <= ST_START;
            tx_reg    <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            state_reg   <= ST_DATA;
            bit_idx_reg <= '0;
            tx_reg      <= byte_reg[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx_reg == 3'd7) begin
`ifdef REG_DUMP_TX_PARITY_EN
              state_reg <= ST_PARITY;
              tx_reg    <= even_parity(byte_reg);
`else
              state_reg <= ST_STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= byte_reg[bit_idx_reg + 3'd1];
            end
          end
        end
`ifdef REG_DUMP_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state_reg <= ST_STOP;
            tx_reg    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (start) begin
              byte_reg  <= byte_in;
              state_reg <= ST_START;
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= ST_IDLE;
              tx_reg    <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_dump_uart_tx.sv
// Register-dump word transmitter: 32-bit word -> 4 UART bytes, MSB byte first.
// Define REG_DUMP_TX_PARITY_EN for 8E1 framing (default 8N1).
module reg_dump_uart_tx
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 868,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  output logic              tx,
  output logic              busy,
  output logic              dump_done
);

  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic              busy_reg;
  logic              last_reg;
  logic              dump_done_reg;
  logic [IDX_W-1:0]  byte_idx_reg;
  logic [IDX_W-1:0]  next_idx;
  logic [WORD_W-1:0] word_reg;
  logic [BYTE_W-1:0] word_bytes [BYTES_PER_WORD];
  logic              accept;
  logic              byte_done;
  logic              more_bytes;
  logic              byte_start;
  logic [BYTE_W-1:0] tx_byte;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_bytes
      assign word_bytes[gi] = word_reg[WORD_W-1-BYTE_W*gi -: BYTE_W];
    end
  endgenerate

  assign word_ready = ~busy_reg & ~rst;
  assign accept     = word_valid & word_ready;
  assign more_bytes = (byte_idx_reg != IDX_W'(BYTES_PER_WORD - 1));
  assign next_idx   = byte_idx_reg + IDX_W'(1);
  assign byte_start = accept | (byte_done & more_bytes);
  // The first byte comes straight from the input bus since word_reg is not loaded yet.
  assign tx_byte    = accept ? word_data[WORD_W-1 -: BYTE_W] : word_bytes[next_idx];
  assign busy       = busy_reg;
  assign dump_done  = dump_done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg      <= 1'b0;
      last_reg      <= 1'b0;
      dump_done_reg <= 1'b0;
      byte_idx_reg  <= '0;
      word_reg      <= '0;
    end else begin
      dump_done_reg <= 1'b0;
      if (accept) begin
        word_reg     <= word_data;
        last_reg     <= word_last;
        byte_idx_reg <= '0;
        busy_reg     <= 1'b1;
      end else if (byte_done) begin
        if (more_bytes) begin
          byte_idx_reg <= next_idx;
        end else begin
          busy_reg      <= 1'b0;
          dump_done_reg <= last_reg;
        end
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk    (clk),
    .rst    (rst),
    .start  (byte_start),
    .byte_in(tx_byte),
    .tx     (tx),
    .done   (byte_done)
  );

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Self-checking bench for reg_dump_uart_tx: expected tx is computed per cycle
// from the frame layout (start, 8 data LSB first, [parity], stop; MSB byte first).
module tb_reg_dump_uart_tx;

  localparam int C = 4;
`ifdef REG_DUMP_TX_PARITY_EN
  localparam int BPB = 11;
`else
  localparam int BPB = 10;
`endif
  localparam int FRAME = 4 * BPB * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] word_data = '0;
  logic        word_valid = 1'b0;
  logic        word_last = 1'b0;
  logic        word_ready, tx, busy, dump_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;

  reg_dump_uart_tx #(.CLKS_PER_BIT(C), .BYTES_PER_WORD(4)) dut (
    .clk(clk), .rst(rst), .word_data(word_data), .word_valid(word_valid),
    .word_last(word_last), .word_ready(word_ready), .tx(tx), .busy(busy),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    bit          last;
    bit          scribble;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected line level k cycles after the first start-bit cycle of word d.
  function automatic logic exp_tx(input logic [31:0] d, input int k);
    int bitpos, byte_n, bp;
    logic [7:0] b;
    bitpos = k / C;
    byte_n = bitpos / BPB;
    bp     = bitpos % BPB;
    b      = d[31 - 8*byte_n -: 8];
    if (bp == 0) return 1'b0;
    if (bp <= 8) return b[bp-1];
    if (BPB == 11 && bp == 9) return ^b;
    return 1'b1;
  endfunction

  // Called just after a negedge; returns just after the idle-cycle negedge.
  task automatic send_word(input logic [31:0] d, input bit last, input bit scribble, input bit keep_valid);
    int waited = 0;
    bit ok = 1'b1;
    word_data = d; word_last = last; word_valid = 1'b1;
    while (!word_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 50) begin ok = 1'b0; break; end
    end
    if (!ok) begin
      chk("ready_timeout", 32'd0, 32'd1);
      word_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_cyc = cyc;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      chk("tx_bit", {31'd0, tx}, {31'd0, exp_tx(d, k)});
      chk("busy_hi", {31'd0, busy}, 32'd1);
      chk("ready_lo", {31'd0, word_ready}, 32'd0);
      chk("done_lo", {31'd0, dump_done}, 32'd0);
      if (scribble) begin
        word_data  = $urandom;
        word_valid = $urandom_range(0, 1);
        word_last  = $urandom_range(0, 1);
      end
    end
    @(negedge clk);
    chk("idle_tx", {31'd0, tx}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ready", {31'd0, word_ready}, 32'd1);
    chk("dump_done", {31'd0, dump_done}, {31'd0, last});
    word_valid = keep_valid;
  endtask

  vec_t vecs [8];

  initial begin
    int first_acc;
    vecs[0] = '{32'hA5C30F01, 1'b0, 1'b0};
    vecs[1] = '{32'h00000000, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[3] = '{32'h80000001, 1'b0, 1'b1};
    vecs[4] = '{32'h07000000, 1'b0, 1'b0};
    vecs[5] = '{32'h55AA33CC, 1'b1, 1'b1};
    vecs[6] = '{32'h0F0F1E1E, 1'b0, 1'b1};
    vecs[7] = '{32'hDEADBEEF, 1'b1, 1'b0};

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, word_ready}, 32'd0);
      chk("rst_done", {31'd0, dump_done}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, word_ready}, 32'd1);

    foreach (vecs[i]) send_word(vecs[i].data, vecs[i].last, vecs[i].scribble, 1'b0);

    // Randomized words with a busy-time scribbling source
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_word($urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    // Full 32-register dump, valid held high throughout
    first_acc = 0;
    for (int i = 0; i < 32; i++) begin
      send_word($urandom, (i == 31), 1'b0, (i != 31));
      if (i == 0) first_acc = acc_cyc;
    end
    chk("dump_len", 32'(acc_cyc - first_acc + FRAME), 32'(32*FRAME + 31));

    // Reset during DATA of byte 2, with last set so a stray dump_done would show
    @(negedge clk);
    word_data = 32'h12345678; word_last = 1'b1; word_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    word_valid = 1'b0;
    for (int k = 1; k < 2*BPB*C + 3*C + 1; k++) begin
      @(negedge clk);
      chk("pre_rst_tx", {31'd0, tx}, {31'd0, exp_tx(32'h12345678, k)});
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, dump_done}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("aftrst_tx", {31'd0, tx}, 32'd1);
      chk("aftrst_done", {31'd0, dump_done}, 32'd0);
      chk("aftrst_ready", {31'd0, word_ready}, 32'd1);
    end
    send_word(32'h00000000, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
